// File: rtl/matrix_coef_pkg.sv
// Shared constants and types for the matrix coefficient bank.
package matrix_coef_pkg;

  // Bit positions inside a control register write.
  localparam int unsigned CTRL_ARM_BIT   = 0;
  localparam int unsigned CTRL_IMM_BIT   = 1;
  localparam int unsigned CTRL_ABORT_BIT = 2;

  localparam int unsigned DEFAULT_DW        = 32;
  localparam int unsigned DEFAULT_AW        = 20;
  localparam logic [19:0] DEFAULT_BASE_ADDR = 20'h00040;

  typedef enum logic {
    StIdle,
    StArmed
  } coef_state_e;

endpackage

// File: rtl/matrix_coef_decode.sv
// Address decoder: classifies a bus address as a coefficient slot, the control
// register, or neither. Misaligned addresses never hit.
module matrix_coef_decode #(
  parameter int unsigned       N_COEF    = 9,
  parameter int unsigned       AW        = 20,
  parameter logic [AW-1:0]     BASE_ADDR = 20'h00040,
  parameter logic [AW-1:0]     CTRL_ADDR = 20'h00064,
  parameter int unsigned       IW        = 4
) (
  input  logic [AW-1:0] addr,
  output logic          hit_coef,
  output logic          hit_ctrl,
  output logic [IW-1:0] index
);

  logic [AW-1:0] word;
  logic          aligned;

  // Word offset from the base, range and alignment checks.
  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    word     = (addr - BASE_ADDR) >> 2;
    hit_coef = aligned && (addr >= BASE_ADDR) && (word < AW'(N_COEF));
    hit_ctrl = aligned && (addr == CTRL_ADDR);
    index    = word[IW-1:0];
  end

endmodule

// File: rtl/matrix_coef_bank.sv
// Double-buffered coefficient bank: software writes shadow registers, then a
// commit copies them to the active set on a frame boundary (or immediately).
// Optional readback of shadow/control is enabled by MATRIX_COEF_READBACK_EN.
module matrix_coef_bank
  import matrix_coef_pkg::*;
#(
  parameter int unsigned   N_COEF    = 9,
  parameter int unsigned   DW        = DEFAULT_DW,
  parameter int unsigned   AW        = DEFAULT_AW,
  parameter logic [AW-1:0] BASE_ADDR = AW'(DEFAULT_BASE_ADDR),
  parameter logic [AW-1:0] CTRL_ADDR = BASE_ADDR + AW'(4 * N_COEF)
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_ack,
  input  logic                 frame_strobe,
  output logic [N_COEF*DW-1:0] coef_active,
  output logic                 commit_pending,
  output logic                 commit_done
);

  localparam int unsigned IW = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  logic [DW-1:0] shadow_q [N_COEF];
  logic [DW-1:0] active_q [N_COEF];
  coef_state_e   state_q, state_d;
  logic          commit_done_q;
  logic          copy;

  logic          w_hit_coef, w_hit_ctrl;
  logic [IW-1:0] w_idx;
  logic          ctrl_wr, ctrl_arm, ctrl_imm, ctrl_abort;

  matrix_coef_decode #(
    .N_COEF    (N_COEF),
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR),
    .CTRL_ADDR (CTRL_ADDR),
    .IW        (IW)
  ) u_wr_decode (
    .addr     (wr_addr),
    .hit_coef (w_hit_coef),
    .hit_ctrl (w_hit_ctrl),
    .index    (w_idx)
  );

  // Control strobes; immediate beats abort, abort beats arm.
  always_comb begin
    ctrl_wr    = wr_en && w_hit_ctrl;
    ctrl_imm   = ctrl_wr && wr_data[CTRL_IMM_BIT];
    ctrl_abort = ctrl_wr && wr_data[CTRL_ABORT_BIT] && !ctrl_imm;
    ctrl_arm   = ctrl_wr && wr_data[CTRL_ARM_BIT] && !ctrl_imm && !ctrl_abort;
  end

  // Commit FSM next-state and copy decision.
  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A strobe in the arming cycle is deliberately ignored: we are still idle.
        if (ctrl_imm) begin
          copy = 1'b1;
        end else if (ctrl_arm) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (ctrl_imm) begin
          copy    = 1'b1;
          state_d = StIdle;
        end else if (ctrl_abort) begin
          state_d = StIdle;
        end else if (frame_strobe) begin
          copy    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and the one-cycle commit_done pulse.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q       <= StIdle;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= copy;
    end
  end

  // Shadow writes and shadow-to-active copy; copy sees the pre-write shadow.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int k = 0; k < int'(N_COEF); k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_COEF); k++) begin
        if (wr_en && w_hit_coef && (w_idx == IW'(k))) begin
          shadow_q[k] <= wr_data;
        end
        if (copy) begin
          active_q[k] <= shadow_q[k];
        end
      end
    end
  end

  for (genvar k = 0; k < int'(N_COEF); k++) begin : g_active
    assign coef_active[k*DW +: DW] = active_q[k];
  end

  assign commit_pending = (state_q == StArmed);
  assign commit_done    = commit_done_q;

`ifdef MATRIX_COEF_READBACK_EN
  logic          r_hit_coef, r_hit_ctrl;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] rd_data_q;
  logic          rd_ack_q;

  matrix_coef_decode #(
    .N_COEF    (N_COEF),
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR),
    .CTRL_ADDR (CTRL_ADDR),
    .IW        (IW)
  ) u_rd_decode (
    .addr     (rd_addr),
    .hit_coef (r_hit_coef),
    .hit_ctrl (r_hit_ctrl),
    .index    (r_idx)
  );

  // Read mux over shadow registers and control status.
  always_comb begin
    rd_mux = '0;
    if (r_hit_coef) begin
      for (int k = 0; k < int'(N_COEF); k++) begin
        if (r_idx == IW'(k)) begin
          rd_mux = shadow_q[k];
        end
      end
    end else if (r_hit_ctrl) begin
      rd_mux = {{(DW-1){1'b0}}, commit_pending};
    end
  end

  // Registered read response; data forced to zero outside the ack cycle.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_en;
      rd_data_q <= rd_en ? rd_mux : '0;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_ack    = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_matrix_coef_bank.sv
// Scoreboard bench for matrix_coef_bank: expected commits and read responses
// are queued by the stimulus and consumed by a negedge monitor.
module tb_matrix_coef_bank;

  localparam int NC = 9;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam logic [AW-1:0] BASE = 20'h00040;
  localparam logic [AW-1:0] CTRL = 20'h00064;
`ifdef MATRIX_COEF_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_ack;
  logic              frame_strobe = 1'b0;
  logic [NC*DW-1:0]  coef_active;
  logic              commit_pending;
  logic              commit_done;

  int checks = 0;
  int errors = 0;

  logic [NC*DW-1:0] ea = '0;
  logic [NC*DW-1:0] commit_q [$];
  logic [DW-1:0]    rd_q [$];

  matrix_coef_bank dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_ack          (rd_ack),
    .frame_strobe    (frame_strobe),
    .coef_active     (coef_active),
    .commit_pending  (commit_pending),
    .commit_done     (commit_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    if (READBACK) rd_q.push_back(exp);
    step();
    rd_en = 1'b0;
    chk({name, "_ack"}, {287'b0, rd_ack}, {287'b0, READBACK});
  endtask

  task automatic set_ea(input int k, input logic [DW-1:0] v);
    ea[k*DW +: DW] = v;
  endtask

  // Monitor: every commit_done and rd_ack must match a queued expectation.
  always @(negedge clk) begin
    if (commit_done) begin
      if (commit_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_commit_done: got 1 expected 0");
      end else begin
        chk("commit_active", coef_active, commit_q.pop_front());
      end
    end
    if (rd_ack) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_ack: got 1 expected 0");
      end else begin
        chk("rd_data", {256'b0, rd_data}, {256'b0, rd_q.pop_front()});
      end
    end else begin
      chk("rd_data_idle", {256'b0, rd_data}, '0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    step(); step();
    chk("rst_active", coef_active, '0);
    chk("rst_pending", {287'b0, commit_pending}, '0);
    chk("rst_done", {287'b0, commit_done}, '0);
    chk("rst_ack", {287'b0, rd_ack}, '0);
    rstn = 1'b1;
    step();

    // Shadow writes leave active untouched.
    wr(BASE, 32'h11);
    wr(BASE + 20'h20, 32'h99);
    chk("shadow_no_active", coef_active, '0);
    rd("rd_c0", BASE, 32'h11);
    rd("rd_c8", BASE + 20'h20, 32'h99);

    // Arm, then strobe two cycles later.
    wr(CTRL, 32'h1);
    chk("armed_pending", {287'b0, commit_pending}, 288'd1);
    step();
    chk("armed_hold", {287'b0, commit_pending}, 288'd1);
    chk("armed_no_copy", coef_active, '0);
    set_ea(0, 32'h11); set_ea(8, 32'h99);
    commit_q.push_back(ea);
    strobe();
    chk("commit_active_0_8", coef_active, ea);
    chk("commit_clears_pending", {287'b0, commit_pending}, '0);
    step();

    // Strobe in the arming cycle does not commit.
    wr(BASE + 20'h8, 32'h33);
    wr_en = 1'b1; wr_addr = CTRL; wr_data = 32'h1; frame_strobe = 1'b1;
    step();
    wr_en = 1'b0; frame_strobe = 1'b0;
    chk("same_cycle_pending", {287'b0, commit_pending}, 288'd1);
    chk("same_cycle_no_copy", coef_active, ea);
    set_ea(2, 32'h33);
    commit_q.push_back(ea);
    strobe();
    chk("next_strobe_copy", coef_active, ea);

    // Coefficient write on the commit edge: active gets the old shadow.
    wr(CTRL, 32'h1);
    commit_q.push_back(ea);
    wr_en = 1'b1; wr_addr = BASE + 20'h4; wr_data = 32'h22; frame_strobe = 1'b1;
    step();
    wr_en = 1'b0; frame_strobe = 1'b0;
    chk("race_active_old", coef_active, ea);
    rd("rd_c1_new", BASE + 20'h4, 32'h22);
    // Read and write of the same slot in one cycle returns the old value.
    wr_en = 1'b1; wr_addr = BASE + 20'h4; wr_data = 32'h23;
    rd("rd_c1_prewrite", BASE + 20'h4, 32'h22);
    wr_en = 1'b0;

    // Immediate commit, alone and together with arm.
    wr(BASE + 20'hC, 32'h44);
    set_ea(1, 32'h23); set_ea(3, 32'h44);
    commit_q.push_back(ea);
    wr(CTRL, 32'h2);
    chk("imm_active", coef_active, ea);
    chk("imm_pending", {287'b0, commit_pending}, '0);
    wr(BASE + 20'h10, 32'h55);
    set_ea(4, 32'h55);
    commit_q.push_back(ea);
    wr(CTRL, 32'h3);
    chk("imm_arm_active", coef_active, ea);
    chk("imm_arm_pending", {287'b0, commit_pending}, '0);

    // Abort: no copy, no commit_done.
    wr(BASE + 20'h14, 32'h66);
    wr(CTRL, 32'h1);
    rd("rd_ctrl_armed", CTRL, 32'h1);
    wr(CTRL, 32'h4);
    chk("abort_pending", {287'b0, commit_pending}, '0);
    strobe();
    step();
    chk("abort_no_copy", coef_active, ea);
    rd("rd_ctrl_idle", CTRL, 32'h0);

    // Repeated arm produces a single commit.
    wr(CTRL, 32'h1);
    wr(CTRL, 32'h1);
    chk("rearm_pending", {287'b0, commit_pending}, 288'd1);
    set_ea(5, 32'h66);
    commit_q.push_back(ea);
    strobe();
    chk("rearm_active", coef_active, ea);
    step(); step();

    // Reset while armed discards the commit.
    wr(BASE + 20'h18, 32'h77);
    wr(CTRL, 32'h1);
    rstn = 1'b0;
    #2;
    chk("rst2_active", coef_active, '0);
    chk("rst2_pending", {287'b0, commit_pending}, '0);
    chk("rst2_done", {287'b0, commit_done}, '0);
    chk("rst2_rd_data", {256'b0, rd_data}, '0);
    step(); step();
    rstn = 1'b1;
    ea = '0;
    strobe();
    step(); step();
    chk("post_rst_active", coef_active, '0);
    chk("post_rst_pending", {287'b0, commit_pending}, '0);

    // Out-of-range and misaligned writes are ignored.
    wr(BASE, 32'hAB);
    wr(BASE + 20'h1000, 32'hDEAD);
    wr(BASE + 20'h2, 32'hBEEF);
    rd("rd_oor", BASE + 20'h1000, 32'h0);
    rd("rd_c0_kept", BASE, 32'hAB);
    set_ea(0, 32'hAB);
    commit_q.push_back(ea);
    wr(CTRL, 32'h2);
    chk("ignored_writes", coef_active, ea);

    step(); step(); step();
    chk("commit_q_empty", 288'(commit_q.size()), '0);
    chk("rd_q_empty", 288'(rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
